// File: rtl/ctrl_sync_multi.sv
// rtl/ctrl_sync_multi.sv - multi-channel async control synchroniser with debounce, edge detect and sticky flags
module ctrl_sync_multi #(
    parameter int              CH          = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_CYC    = 0,
    parameter logic [2*CH-1:0] MODE        = {CH{2'b01}},
    parameter logic            RST_VAL     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] async_i,
    input  logic [CH-1:0] ack_i,
    output logic [CH-1:0] lvl_o,
    output logic [CH-1:0] pulse_o,
    output logic [CH-1:0] flag_o,
    output logic [CH-1:0] ovf_o
);

    // Fewer than two flops cannot resolve metastability, so clamp upward.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // Counter must hold FILT_CYC; keep at least one bit so the bypass case still elaborates.
    localparam int CW = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYC);

    logic [CH-1:0] sync_q [SS];
    logic [CW-1:0] cnt_q  [CH];
    logic [CW-1:0] cnt_d  [CH];
    logic [CH-1:0] sync_s;
    logic [CH-1:0] lvl_d;
    logic [CH-1:0] mode_rise;
    logic [CH-1:0] mode_fall;
    logic [CH-1:0] event_d;
    logic [CH-1:0] flag_d;
    logic [CH-1:0] ovf_d;

    assign sync_s = sync_q[SS-1];

    // Synchroniser chain: async inputs only ever reach logic through SS flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SS; k++) begin
                sync_q[k] <= {CH{RST_VAL}};
            end
        end else begin
            sync_q[0] <= async_i;
            for (int k = 1; k < SS; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Debounce: level flips once the synchronised value has disagreed for FILT_CYC+1 samples.
    always_comb begin
        lvl_d = lvl_o;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != lvl_o[i]) begin
                if (cnt_q[i] == FILT_MAX) begin
                    lvl_d[i] = ~lvl_o[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Per-channel edge selection from the packed MODE vector.
    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        for (int i = 0; i < CH; i++) begin
            mode_rise[i] = MODE[2*i];
            mode_fall[i] = MODE[2*i+1];
        end
    end

    assign event_d = (lvl_d & ~lvl_o & mode_rise) | (~lvl_d & lvl_o & mode_fall);

    // Sticky flag/overflow: an ack coincident with an event retires the old event and keeps the new one.
    always_comb begin
        flag_d = flag_o;
        ovf_d  = ovf_o;
        for (int i = 0; i < CH; i++) begin
            if (event_d[i] && ack_i[i]) begin
                flag_d[i] = 1'b1;
                ovf_d[i]  = 1'b0;
            end else if (event_d[i] && flag_o[i]) begin
                ovf_d[i]  = 1'b1;
            end else if (event_d[i]) begin
                flag_d[i] = 1'b1;
            end else if (ack_i[i]) begin
                flag_d[i] = 1'b0;
                ovf_d[i]  = 1'b0;
            end
        end
    end

    // Output and filter state registers; reset discards pending counts and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
            lvl_o   <= {CH{RST_VAL}};
            pulse_o <= '0;
            flag_o  <= '0;
            ovf_o   <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            lvl_o   <= lvl_d;
            pulse_o <= event_d;
            flag_o  <= flag_d;
            ovf_o   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ctrl_sync_multi.sv
// tb/tb_ctrl_sync_multi.sv - scoreboard bench for ctrl_sync_multi
module tb_ctrl_sync_multi;

    localparam int         CH   = 4;
    localparam int         SS   = 2;
    localparam int         F    = 3;
    localparam logic [7:0] MODE = 8'b11_10_01_00;
    localparam logic       RV   = 1'b0;
    localparam int         LAT  = SS + F + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] async_i;
    logic [CH-1:0] ack_i;
    logic [CH-1:0] lvl_o;
    logic [CH-1:0] pulse_o;
    logic [CH-1:0] flag_o;
    logic [CH-1:0] ovf_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pulse;
        logic [CH-1:0] flag;
        logic [CH-1:0] ovf;
    } exp_t;

    exp_t          exp_q [$];
    logic [CH-1:0] m_hist [$];
    logic [CH-1:0] m_shist [$];
    logic [CH-1:0] m_lvl, m_pulse, m_flag, m_ovf;

    always #5 clk = ~clk;

    ctrl_sync_multi #(
        .CH(CH), .SYNC_STAGES(SS), .FILT_CYC(F), .MODE(MODE), .RST_VAL(RV)
    ) dut (
        .clk(clk), .rst(rst), .async_i(async_i), .ack_i(ack_i),
        .lvl_o(lvl_o), .pulse_o(pulse_o), .flag_o(flag_o), .ovf_o(ovf_o)
    );

    // Reference: the synchroniser is a pure SS-edge delay; a level flips when the
    // last F+1 post-reset samples all disagree with it; flags follow the priority rules.
    task automatic model_edge(input logic r, input logic [CH-1:0] a, input logic [CH-1:0] k);
        logic [CH-1:0] s, nl, ev;
        logic          all_diff;
        if (r) begin
            m_hist.delete();
            for (int i = 0; i < SS; i++) m_hist.push_back({CH{RV}});
            m_shist.delete();
            m_lvl = {CH{RV}}; m_pulse = '0; m_flag = '0; m_ovf = '0;
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(a);
            m_shist.push_back(s);
            if (m_shist.size() > F + 1) m_shist.delete(0);
            nl = m_lvl;
            for (int c = 0; c < CH; c++) begin
                if (m_shist.size() == F + 1) begin
                    all_diff = 1'b1;
                    foreach (m_shist[j]) if (m_shist[j][c] == m_lvl[c]) all_diff = 1'b0;
                    if (all_diff) nl[c] = ~m_lvl[c];
                end
                ev[c] = (nl[c] && !m_lvl[c] && MODE[2*c]) || (!nl[c] && m_lvl[c] && MODE[2*c+1]);
                if (ev[c] && k[c]) begin
                    m_flag[c] = 1'b1; m_ovf[c] = 1'b0;
                end else if (ev[c] && m_flag[c]) begin
                    m_ovf[c] = 1'b1;
                end else if (ev[c]) begin
                    m_flag[c] = 1'b1;
                end else if (k[c]) begin
                    m_flag[c] = 1'b0; m_ovf[c] = 1'b0;
                end
            end
            m_lvl   = nl;
            m_pulse = ev;
        end
        exp_q.push_back({m_lvl, m_pulse, m_flag, m_ovf});
    endtask

    task automatic step(input logic r, input logic [CH-1:0] a, input logic [CH-1:0] k);
        rst     = r;
        async_i = a;
        ack_i   = k;
        @(posedge clk);
        model_edge(r, a, k);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: compare every registered output word against the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({lvl_o, pulse_o, flag_o, ovf_o} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got lvl=%b pulse=%b flag=%b ovf=%b want lvl=%b pulse=%b flag=%b ovf=%b",
                         $time, lvl_o, pulse_o, flag_o, ovf_o, e.lvl, e.pulse, e.flag, e.ovf);
            end
        end
    end

    initial begin
        logic [CH-1:0] acc;
        logic [CH-1:0] cur_a;
        logic [CH-1:0] k;
        int            n;
        int            pc [CH];

        rst = 1'b1; async_i = '0; ack_i = '0;
        repeat (3) step(1'b1, '0, '0);
        acc = '0;
        repeat (20) begin
            step(1'b0, '0, '0);
            acc |= lvl_o | pulse_o | flag_o | ovf_o;
        end
        check("idle_after_reset", acc, 0);

        n = 0;
        while (n < 50) begin
            n++;
            step(1'b0, 4'b0001, '0);
            if (lvl_o[0]) break;
        end
        check("latency_ch0", n, LAT);

        acc = '0;
        repeat (F) begin step(1'b0, 4'b0011, '0); acc |= lvl_o & 4'b0010; end
        repeat (12) begin step(1'b0, 4'b0001, '0); acc |= lvl_o & 4'b0010; end
        check("glitch_short_suppressed", acc, 0);
        acc = '0;
        repeat (F + 1) begin step(1'b0, 4'b0011, '0); acc |= lvl_o & 4'b0010; end
        repeat (10) begin step(1'b0, 4'b0001, '0); acc |= lvl_o & 4'b0010; end
        check("glitch_min_passes", acc, 4'b0010);

        repeat (15) step(1'b0, '0, '0);
        foreach (pc[c]) pc[c] = 0;
        repeat (10) begin step(1'b0, 4'b1111, '0); foreach (pc[c]) pc[c] += int'(pulse_o[c]); end
        repeat (10) begin step(1'b0, 4'b0000, '0); foreach (pc[c]) pc[c] += int'(pulse_o[c]); end
        repeat (10) begin step(1'b0, 4'b0000, '0); foreach (pc[c]) pc[c] += int'(pulse_o[c]); end
        check("mode00_pulses", pc[0], 0);
        check("mode01_pulses", pc[1], 1);
        check("mode10_pulses", pc[2], 1);
        check("mode11_pulses", pc[3], 2);

        step(1'b0, '0, 4'b1111);
        repeat (2) begin
            repeat (8) step(1'b0, 4'b0010, '0);
            repeat (8) step(1'b0, 4'b0000, '0);
        end
        check("ovf_flag_set", flag_o[1], 1);
        check("ovf_set", ovf_o[1], 1);
        step(1'b0, '0, 4'b0010);
        check("ack_clears", {flag_o[1], ovf_o[1]}, 0);
        repeat (8) step(1'b0, 4'b0010, '0);
        repeat (8) step(1'b0, 4'b0000, '0);
        repeat (LAT - 1) step(1'b0, 4'b0010, '0);
        step(1'b0, 4'b0010, 4'b0010);
        check("coincident_pulse", pulse_o[1], 1);
        check("coincident_flag_ovf", {flag_o[1], ovf_o[1]}, 2'b10);

        repeat (SS + 2) step(1'b0, 4'b0011, '0);
        check("flag_before_reset", flag_o[1], 1);
        step(1'b1, 4'b0011, '0);
        check("reset_mid_filter", {lvl_o, pulse_o, flag_o, ovf_o}, 0);
        n = 0;
        while (n < 50) begin
            n++;
            step(1'b0, 4'b0011, '0);
            if (lvl_o[0]) break;
        end
        check("latency_after_reset", n, LAT);

        cur_a = 4'b0011;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) cur_a[c] = ~cur_a[c];
                k[c] = ($urandom_range(7) == 0);
            end
            step(($urandom_range(299) == 0), cur_a, k);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sync_multi.md
Name: ctrl_sync_multi

Overview:
- Multi-channel synchroniser for asynchronous control inputs into a single clock domain.
- Per channel, in this order: an N-stage synchroniser, an optional glitch/debounce filter, and mode-selectable edge detection.
- Edge events produce a one-cycle pulse and a sticky event flag. The flag is held until software/logic acknowledges it, with overflow detection for missed events.
- Sits at the boundary where board-level/async control lines (button, GPIO, status from other domains) enter the core.

Parameters:
- CH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (minimum 2; values <2 treated as 2).
- FILT_CYC, 0: debounce length in clk cycles (0 = filter bypassed; max 65535).
- MODE, {CH{2'b01}}: 2 bits per channel, channel i at [2i+1:2i]. 00 = level only, 01 = rising edge, 10 = falling edge, 11 = both edges.
- RST_VAL, 0: reset value (1 bit, applied to all channels) of synchroniser flops and filtered level.

Ports:
- clk, input, 1: destination clock.
- rst, input, 1: synchronous reset, active-high.
- async_i, input, CH: asynchronous control inputs.
- ack_i, input, CH: per-channel flag/overflow clear, sampled on clk.
- lvl_o, output, CH: synchronised, filtered level.
- pulse_o, output, CH: one-cycle event pulse per mode.
- flag_o, output, CH: sticky event flag.
- ovf_o, output, CH: sticky overflow (event arrived while flag_o already set and not acked).

Behaviour:
- Reset: rst sampled high at posedge clk takes priority over all other logic.
  - Synchroniser flops, lvl_o and filter counters go to RST_VAL / 0.
  - pulse_o, flag_o and ovf_o go to 0.
  - Reset mid-operation discards in-progress filter counts and pending flags.
  - After release with async_i == RST_VAL, no pulse is generated.
- Synchroniser: async_i[i] → SYNC_STAGES flops in series; s[i] is the last stage. There is no combinational path from async_i.
- Filter: per-channel counter, width clog2(FILT_CYC+1).
  - While s[i] == lvl_o[i], the counter is held at 0.
  - While s[i] != lvl_o[i], the counter increments each cycle.
  - lvl_o[i] toggles on the edge where the difference has persisted for FILT_CYC+1 consecutive samples; the counter clears on that same edge.
  - Any return to equality before then clears the counter. Glitches shorter than FILT_CYC+1 cycles at s[i] are therefore suppressed.
  - FILT_CYC=0: lvl_o follows s[i] one cycle later.
- Latency: a change on async_i that is stable before edge 1 appears on lvl_o after edge SYNC_STAGES+FILT_CYC+1.
- Edge detect: event[i] = (lvl_o toggles 0→1 this edge and MODE bit0) or (lvl_o toggles 1→0 this edge and MODE bit1). pulse_o[i] is registered and asserted for exactly one cycle, on the same edge lvl_o changes. MODE 00 never pulses.
- Flag/overflow update per edge, evaluated in this priority order:
  - If event and ack: flag_o=1, ovf_o=0. The ack clears the old event; the new event sets the flag.
  - Else if event and flag_o==1: ovf_o=1, flag_o stays 1.
  - Else if event: flag_o=1.
  - Else if ack: flag_o=0, ovf_o=0.
  - Ack with flag_o=0 has no effect.
- Channels are fully independent; one channel's ack never affects another.
- Minimum event spacing with no loss of pulse_o: one event per FILT_CYC+1 cycles per polarity. Flag/ovf capture every event regardless of spacing.

Test Plan:
- Reset/idle: RST_VAL=0, async_i=0, rst for 3 cycles then release → lvl_o=0, pulse_o/flag_o/ovf_o stay 0 for 20 cycles.
- Latency, rise mode: CH=4, SYNC_STAGES=2, FILT_CYC=0, set async_i[0]=1 before edge 1 → lvl_o[0]=1 and pulse_o[0]=1 after edge 3, pulse_o[0]=0 after edge 4, flag_o[0]=1 held.
- Debounce: FILT_CYC=4, 3-cycle high glitch on async_i[1] → no lvl_o/pulse change; 5-cycle high → lvl_o[1] rises after edge 2+4+1=7 from the first sampled edge.
- Modes: MODE=8'b11_10_01_00, toggle all inputs 0→1→0 (each held 10 cycles).
  - ch0 → no pulses.
  - ch1 → 1 pulse (rise).
  - ch2 → 1 pulse (fall).
  - ch3 → 2 pulses.
- Overflow and ack: two rising events on ch0 without ack → flag_o[0]=1, ovf_o[0]=1. Then:
  - ack_i[0] for 1 cycle → both 0.
  - ack coincident with a new event → flag_o[0]=1, ovf_o[0]=0.
- Reset mid-filter: FILT_CYC=8, assert rst when the counter is at 5 with flag_o=1 → next cycle all outputs 0, counter 0; after release, an 8-cycle-stable input still needs 9 fresh samples to toggle.
